pb_debouncer: RTL and testbench
===============================

# pb_debouncer

Front-end for every push-button in the clock. Takes the raw, asynchronous, bouncing pin from a Nexys4 DDR push-button and synchronizes it into `clk`. It accepts a level change only after the level has held for `T_STABLE` cycles. It then produces the clean level and one-cycle press/release pulses that the downstream button controller consumes. One instance is used per button.

## Interface
Parameters:
- `T_STABLE`, default `1_000_000`: consecutive cycles the synchronized input must hold a new level before it is accepted. Legal range is `T_STABLE >= 2`.
- `T_STABLE_WIDTH`, default `$clog2(T_STABLE)`: width of the stability counter.

Ports:
- `clk` input, 1 bit: system clock.
- `rst` input, 1 bit: reset, synchronous, active-high. Reset is `rst`, synchronous, active-high; clock is `clk`.
- `PB` input, 1 bit: raw button pin, asynchronous, active-high, may bounce.
- `PB_pressed_status` output, 1 bit: debounced level, 1 while the button is accepted as pressed.
- `PB_pressed_pulse` output, 1 bit: one-cycle pulse when a press is accepted.
- `PB_released_pulse` output, 1 bit: one-cycle pulse when a release is accepted.

## Operation
- The synchronizer is a 2-flop chain, `PB` to `pb_sync`. Flops reset to 0.
- The FSM has four states: `RELEASED`, `WAIT_PRESS`, `PRESSED`, `WAIT_RELEASE`.
- **RELEASED:**
  - If `pb_sync==1`, go to `WAIT_PRESS` and clear the counter to 0.
  - Otherwise stay.
- **WAIT_PRESS:**
  - If `pb_sync==0`, the event is a glitch: return to `RELEASED` and clear the counter.
  - Else if `count == T_STABLE-1`, go to `PRESSED`.
  - Otherwise increment the counter.
- **PRESSED:** mirror of `RELEASED`. `pb_sync==0` moves to `WAIT_RELEASE` with the counter cleared.
- **WAIT_RELEASE:**
  - If `pb_sync==1`, return to `PRESSED`.
  - Else if `count == T_STABLE-1`, go to `RELEASED`.
  - Otherwise increment the counter.
- All outputs are registered:
  - `PB_pressed_status` is 1 in `PRESSED` and `WAIT_RELEASE`.
  - `PB_pressed_pulse` is 1 exactly in the cycle after the `WAIT_PRESS`→`PRESSED` transition edge.
  - `PB_released_pulse` is 1 exactly in the cycle after the `WAIT_RELEASE`→`RELEASED` transition edge.
- Counter rules:
  - The counter is unsigned, `T_STABLE_WIDTH` bits wide, and never wraps. It stops at `T_STABLE-1` because the state changes on that edge.
  - The counter is held at 0 in `RELEASED` and `PRESSED`.
- Boundary cases:
  - The two pulses are never high in the same cycle.
  - Consecutive pulses are separated by at least `T_STABLE+1` cycles.
  - A bounce during a `WAIT_*` state fully restarts the stability window. There is no partial credit.
- Reset behaviour:
  - `rst` in any cycle, including mid-count, forces `RELEASED`, clears the counter and the synchronizer, and drives all outputs to 0 on the next edge.
  - If `PB` is held high through reset, it is debounced afterwards as a fresh press and produces a pulse.

## Timing
- Reset values: `PB_pressed_status=0`, `PB_pressed_pulse=0`, `PB_released_pulse=0`, state `RELEASED`, `count=0`.
- Take edge 0 as the first edge that samples `PB` at its new level, with the level held afterwards:
  - `pb_sync` changes at edge 1.
  - The FSM enters `WAIT_*` at edge 2.
  - `count = T_STABLE-1` after edge `T_STABLE+1`.
  - Outputs change at edge `T_STABLE+2`.
- Latency from pin to accepted event is therefore `T_STABLE+2` cycles. Each pulse is 1 cycle wide.
- The status level changes on the same edge that the pulse rises.

## Configuration
- Macro: `PB_SYNC3_EN`.
- When defined, the synchronizer has 3 flops. All latencies grow by 1: outputs change at edge `T_STABLE+3`.
- When undefined, the synchronizer has 2 flops with the timing above.
- FSM behaviour is otherwise identical in both builds.

## Structure
- Package `pb_pkg`:
  - typedef enum `pb_state_t` with values `{RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE}`.
  - Constant `PB_T_STABLE_DEFAULT = 1_000_000`.
  - Constant `PB_SYNC_STAGES`, which is 2, or 3 under `PB_SYNC3_EN`.
- Sub-module `pb_synchronizer`:
  - Parameterized by `STAGES`, with synchronous reset to 0.
  - Instantiated once inside `pb_debouncer`.

## Test plan
All scenarios use `T_STABLE=4` and the default build.
- **Clean press:** `PB` rises before edge 0 and is held. At edge 6, `PB_pressed_status` becomes 1 and `PB_pressed_pulse` becomes 1 for exactly one cycle. There is no release pulse.
- **Glitch:** `PB` is high for 3 cycles, then low. All outputs stay 0 and the FSM returns to `RELEASED`.
- **Bounce then settle:** `PB` goes 1,1,0,1 and then stays 1 from edge 3. The pulse occurs at edge 9, with the window restarted from the last rising sample.
- **Clean release:** after a press, `PB` falls before edge 0. At edge 6, status becomes 0 and `PB_released_pulse` is 1 for one cycle.
- **Reset mid-count:** `rst` is asserted at edge 4 of a press window while `PB` is held high, then released at edge 5. Outputs are 0 at edge 5. The press is reaccepted with the pulse at edge `5+6` = 11.
- **With `PB_SYNC3_EN` defined:** the clean-press scenario produces the pulse at edge 7.

Source files
------------

// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - shared types and constants for the push-button debouncer
//
// Purpose: debouncer FSM state encoding, default stability window and
//          synchronizer depth. Optional build macro: PB_SYNC3_EN selects a
//          3-flop synchronizer instead of the default 2-flop chain.
// Ports:   none (package).

package pb_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      WAIT_PRESS   = 2'd1,
      PRESSED      = 2'd2,
      WAIT_RELEASE = 2'd3
   } pb_state_t;

   localparam int PB_T_STABLE_DEFAULT = 1_000_000;

`ifdef PB_SYNC3_EN
   localparam int PB_SYNC_STAGES = 3;
`else
   localparam int PB_SYNC_STAGES = 2;
`endif

   // The button is considered down once a press has been accepted and until
   // a release has been accepted, so WAIT_RELEASE still reports pressed.
   function automatic logic pb_is_down(input pb_state_t st);
      return (st == PRESSED) || (st == WAIT_RELEASE);
   endfunction

endpackage

// File: rtl/pb_synchronizer.sv
// rtl/pb_synchronizer.sv - multi-flop synchronizer for an asynchronous pin
//
// Purpose: brings an asynchronous single-bit input into the clk domain.
// Parameters:
//   STAGES - number of flops in the chain (>= 2)
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset, clears every stage to 0
//   d   - asynchronous input
//   q   - synchronized output (last stage of the chain)

module pb_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_ff;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_ff <= '0;
      end else begin
         sync_ff <= {sync_ff[STAGES-2:0], d};
      end
   end

   assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/pb_debouncer.sv
// rtl/pb_debouncer.sv - push-button synchronizer, debouncer and edge pulser
//
// Purpose: synchronizes a raw bouncing push-button pin, accepts a new level
//          only after it has held for T_STABLE consecutive cycles, and
//          produces a registered clean level plus one-cycle press/release
//          pulses. Optional build macro: PB_SYNC3_EN (3-flop synchronizer,
//          all latencies one cycle longer).
// Parameters:
//   T_STABLE       - cycles a new level must hold before acceptance (>= 2)
//   T_STABLE_WIDTH - width of the stability counter
// Ports:
//   clk               - system clock
//   rst               - synchronous active-high reset
//   PB                - raw asynchronous button pin, active-high
//   PB_pressed_status - debounced level, 1 while accepted as pressed
//   PB_pressed_pulse  - one-cycle pulse when a press is accepted
//   PB_released_pulse - one-cycle pulse when a release is accepted

module pb_debouncer
   import pb_pkg::*;
#(
   parameter int T_STABLE       = PB_T_STABLE_DEFAULT,
   parameter int T_STABLE_WIDTH = $clog2(T_STABLE)
) (
   input  logic clk,
   input  logic rst,
   input  logic PB,
   output logic PB_pressed_status,
   output logic PB_pressed_pulse,
   output logic PB_released_pulse
);

   localparam logic [T_STABLE_WIDTH-1:0] COUNT_LAST = T_STABLE_WIDTH'(T_STABLE - 1);
   localparam logic [T_STABLE_WIDTH-1:0] COUNT_ONE  = T_STABLE_WIDTH'(1);

   logic                      pb_sync;
   pb_state_t                 state;
   pb_state_t                 state_next;
   logic [T_STABLE_WIDTH-1:0] count;
   logic [T_STABLE_WIDTH-1:0] count_next;
   logic                      status_next;
   logic                      press_next;
   logic                      release_next;

   pb_synchronizer #(
      .STAGES (PB_SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (PB),
      .q   (pb_sync)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= RELEASED;
         count             <= '0;
         PB_pressed_status <= 1'b0;
         PB_pressed_pulse  <= 1'b0;
         PB_released_pulse <= 1'b0;
      end else begin
         state             <= state_next;
         count             <= count_next;
         PB_pressed_status <= status_next;
         PB_pressed_pulse  <= press_next;
         PB_released_pulse <= release_next;
      end
   end

   // The counter defaults to 0 every cycle, so it is held at 0 in the stable
   // states and any bounce during a WAIT_* state restarts the window from
   // scratch. It only advances while the candidate level keeps holding and
   // never reaches past COUNT_LAST because the state leaves on that edge.
   always_comb begin
      state_next = state;
      count_next = '0;
      unique case (state)
         RELEASED: begin
            if (pb_sync) begin
               state_next = WAIT_PRESS;
            end
         end
         WAIT_PRESS: begin
            if (!pb_sync) begin
               state_next = RELEASED;
            end else if (count == COUNT_LAST) begin
               state_next = PRESSED;
            end else begin
               count_next = count + COUNT_ONE;
            end
         end
         PRESSED: begin
            if (!pb_sync) begin
               state_next = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (pb_sync) begin
               state_next = PRESSED;
            end else if (count == COUNT_LAST) begin
               state_next = RELEASED;
            end else begin
               count_next = count + COUNT_ONE;
            end
         end
         default: begin
            state_next = RELEASED;
         end
      endcase
   end

   // Outputs are decoded from the transition being taken and registered, so
   // status and the matching pulse rise on the same edge as the state change.
   always_comb begin
      status_next  = pb_is_down(state_next);
      press_next   = (state == WAIT_PRESS)   && (state_next == PRESSED);
      release_next = (state == WAIT_RELEASE) && (state_next == RELEASED);
   end

endmodule

// File: tb/tb_pb_debouncer.sv
// tb/tb_pb_debouncer.sv - directed self-checking bench for pb_debouncer (T_STABLE=4)

module tb_pb_debouncer;

   logic clk = 1'b0;
   logic rst;
   logic PB;
   logic PB_pressed_status;
   logic PB_pressed_pulse;
   logic PB_released_pulse;

   int passed = 0;
   int total  = 0;
   int failed = 0;

   pb_debouncer #(
      .T_STABLE (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .PB                (PB),
      .PB_pressed_status (PB_pressed_status),
      .PB_pressed_pulse  (PB_pressed_pulse),
      .PB_released_pulse (PB_released_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // Advance one active edge, then sample 1 time unit later.
   task automatic cyc(input string tag, input int e, input logic es, input logic epp, input logic erp);
      @(posedge clk);
      #1;
      chk($sformatf("%s e%0d status", tag, e), PB_pressed_status, es);
      chk($sformatf("%s e%0d press", tag, e), PB_pressed_pulse, epp);
      chk($sformatf("%s e%0d release", tag, e), PB_released_pulse, erp);
   endtask

   logic [3:0] bounce_pat;

   initial begin
      rst = 1'b1;
      PB  = 1'b0;
      cyc("reset", 0, 1'b0, 1'b0, 1'b0);
      cyc("reset", 1, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      cyc("idle", 0, 1'b0, 1'b0, 1'b0);
      cyc("idle", 1, 1'b0, 1'b0, 1'b0);

      // Glitch: high for 3 samples then low; nothing may be accepted.
      for (int i = 0; i < 12; i++) begin
         PB = (i < 3);
         cyc("glitch", i, 1'b0, 1'b0, 1'b0);
      end

      // Clean press: accepted at edge 6, proving the FSM was back in RELEASED.
      PB = 1'b1;
      for (int i = 0; i < 11; i++) begin
         cyc("press", i, (i >= 6), (i == 6), 1'b0);
      end

      // Clean release: accepted at edge 6.
      PB = 1'b0;
      for (int i = 0; i < 11; i++) begin
         cyc("release", i, (i < 6), 1'b0, (i == 6));
      end

      // Bounce 1,1,0,1 then held high: window restarts, pulse at edge 9.
      bounce_pat = 4'b1011;
      for (int i = 0; i < 14; i++) begin
         PB = (i < 4) ? bounce_pat[i] : 1'b1;
         cyc("bounce", i, (i >= 9), (i == 9), 1'b0);
      end

      // Release bounce: low for 2 samples then high; stays pressed, no pulses.
      for (int i = 0; i < 10; i++) begin
         PB = !(i < 2);
         cyc("relbounce", i, 1'b1, 1'b0, 1'b0);
      end

      // Release to get back to idle.
      PB = 1'b0;
      for (int i = 0; i < 9; i++) begin
         cyc("release2", i, (i < 6), 1'b0, (i == 6));
      end

      // Reset mid-count with PB held high: press re-accepted at edge 11.
      PB = 1'b1;
      for (int i = 0; i < 14; i++) begin
         rst = (i == 4);
         cyc("rstmid", i, (i >= 11), (i == 11), 1'b0);
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
